wb_i2c_fifo_master: RTL

Queued Wishbone I2C master with its own bit engine, a command FIFO and a receive FIFO, all parametrised. The MCU writes a sequence of START / WRITE / READ / STOP commands and the engine runs them back-to-back, so software does not service every byte. It adds three things the simple I2C peripheral lacks: a runtime SCL divider, slave clock-stretching support, and automatic STOP on NACK. It sits on the peripheral register bus beside the other wb_* peripherals.

---
 rtl/wb_i2c_fifo_master.sv | 274 +++++++++++++++++++++++++++
 1 files changed

// File: rtl/wb_i2c_fifo_master.sv
// Queued Wishbone I2C master: command FIFO feeding a bit engine with a runtime
// SCL divider, clock-stretch support and automatic STOP on NACK; RX FIFO for reads.
`ifndef MM_REG_ADDR_BITS
`define MM_REG_ADDR_BITS 4
`endif

module wb_i2c_fifo_master #(
  parameter logic [`MM_REG_ADDR_BITS-1:0] REG_ADDR_CSR  = `MM_REG_ADDR_BITS'(0),
  parameter logic [`MM_REG_ADDR_BITS-1:0] REG_ADDR_CMD  = `MM_REG_ADDR_BITS'(1),
  parameter logic [`MM_REG_ADDR_BITS-1:0] REG_ADDR_DATA = `MM_REG_ADDR_BITS'(2),
  parameter logic [`MM_REG_ADDR_BITS-1:0] REG_ADDR_DIV  = `MM_REG_ADDR_BITS'(3),
  parameter int                           FIFO_DEPTH_LOG2 = 3,
  parameter logic [7:0]                   DEFAULT_DIV   = 8'd250
) (
  input  logic                         clk,
  input  logic                         sync_reset,
  input  logic                         stb_i,
  input  logic                         we_i,
  input  logic [`MM_REG_ADDR_BITS-1:0] adr_wr_i,
  input  logic [`MM_REG_ADDR_BITS-1:0] adr_rd_i,
  input  logic [7:0]                   dat_i,
  output logic [7:0]                   dat_o,
  output logic                         ack_o,
  input  logic                         sda_in,
  input  logic                         scl_in,
  output logic                         sda_out,
  output logic                         scl_out,
  output logic [2:0]                   dbg_state
);
  localparam int PW    = FIFO_DEPTH_LOG2;
  localparam int DEPTH = 1 << FIFO_DEPTH_LOG2;
  localparam logic [1:0] OP_START = 2'd0, OP_STOP = 2'd1, OP_WRITE = 2'd2, OP_READ = 2'd3;

  typedef enum logic [2:0] {S_IDLE, S_FETCH, S_START, S_STOP, S_XFER} state_t;
  state_t state, next_state;

  logic                         wr_v;
  logic [`MM_REG_ADDR_BITS-1:0] wr_a;
  logic [7:0]                   wr_d;
  logic enable, nack_seen, overflow;
  logic [7:0] q_reg, tx_stage;

  logic [10:0]  cmd_mem [DEPTH];
  logic [PW-1:0] cmd_wp, cmd_rp;
  logic [PW:0]   cmd_cnt;
  logic [7:0]   rx_mem [DEPTH];
  logic [PW-1:0] rx_wp, rx_rp;
  logic [PW:0]   rx_cnt;

  logic [7:0] q_cnt, q_cur, shreg, cur_byte;
  logic [1:0] phase, cur_op;
  logic [3:0] bit_cnt;
  logic       cur_nack, ack_bit, fetch_wait;
  logic       sda_nxt, scl_nxt;

  logic csr_wr, cmd_wr, data_wr, div_wr, fifo_flush, cmd_flush;
  logic cmd_full, cmd_empty, rx_full, rx_empty, cmd_push, cmd_pop, rx_push, rx_pop;
  logic [10:0] head;
  logic timed, stretch_hold, tick, state_end, fetch_go, nack_evt, sample, tx_bit;
  logic [7:0] status;

  // Bus writes go through one register stage before touching any state.
  always_ff @(posedge clk) begin
    if (sync_reset) begin
      wr_v <= 1'b0;
      wr_a <= '0;
      wr_d <= 8'h00;
    end else begin
      wr_v <= stb_i & we_i;
      wr_a <= adr_wr_i;
      wr_d <= dat_i;
    end
  end

  assign csr_wr     = wr_v & (wr_a == REG_ADDR_CSR);
  assign cmd_wr     = wr_v & (wr_a == REG_ADDR_CMD);
  assign data_wr    = wr_v & (wr_a == REG_ADDR_DATA);
  assign div_wr     = wr_v & (wr_a == REG_ADDR_DIV);
  assign fifo_flush = csr_wr & wr_d[2];

  assign cmd_full  = (cmd_cnt == (PW+1)'(DEPTH));
  assign cmd_empty = (cmd_cnt == '0);
  assign rx_full   = (rx_cnt == (PW+1)'(DEPTH));
  assign rx_empty  = (rx_cnt == '0);
  assign head      = cmd_mem[cmd_rp];

  assign timed        = (state == S_START) || (state == S_STOP) || (state == S_XFER);
  assign stretch_hold = (state == S_XFER) && (phase == 2'd1 || phase == 2'd2) && !scl_in;
  assign tick         = timed && (q_cnt == q_cur - 8'd1) && !stretch_hold;
  assign state_end    = tick && (phase == 2'd3) && (state != S_XFER || bit_cnt == 4'd8);
  assign sample       = tick && (state == S_XFER) && (phase == 2'd2);
  assign fetch_go     = (state == S_FETCH) && !fetch_wait && !cmd_empty &&
                        !(head[9:8] == OP_READ && rx_full);
  assign nack_evt     = state_end && (state == S_XFER) && (cur_op == OP_WRITE) && ack_bit;
  assign cmd_pop      = fetch_go;
  assign cmd_flush    = fifo_flush | nack_evt;
  assign cmd_push     = cmd_wr & (!cmd_full | cmd_pop);
  assign rx_pop       = stb_i & ~we_i & (adr_rd_i == REG_ADDR_DATA) & ~rx_empty;
  assign rx_push      = state_end && (state == S_XFER) && (cur_op == OP_READ) && (!rx_full || rx_pop);

  always_ff @(posedge clk) begin
    if (sync_reset) begin
      enable    <= 1'b0;
      nack_seen <= 1'b0;
      overflow  <= 1'b0;
      q_reg     <= DEFAULT_DIV;
      tx_stage  <= 8'h00;
    end else begin
      if (csr_wr) enable <= wr_d[0];
      if (div_wr) q_reg <= (wr_d == 8'h00) ? 8'd1 : wr_d;
      if (data_wr) tx_stage <= wr_d;
      if (csr_wr && wr_d[1]) begin
        nack_seen <= 1'b0;
        overflow  <= 1'b0;
      end
      if (cmd_wr && cmd_full && !cmd_pop) overflow <= 1'b1;
      if (nack_evt) nack_seen <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (sync_reset || cmd_flush) begin
      cmd_wp  <= '0;
      cmd_rp  <= '0;
      cmd_cnt <= '0;
    end else begin
      if (cmd_push) begin
        cmd_mem[cmd_wp] <= {wr_d[2], wr_d[1:0], tx_stage};
        cmd_wp <= cmd_wp + PW'(1);
      end
      if (cmd_pop) cmd_rp <= cmd_rp + PW'(1);
      cmd_cnt <= cmd_cnt + (PW+1)'(cmd_push) - (PW+1)'(cmd_pop);
    end
  end

  // A byte finishing in the same cycle as a flush still lands in the RX FIFO.
  always_ff @(posedge clk) begin
    if (sync_reset) begin
      rx_wp  <= '0;
      rx_rp  <= '0;
      rx_cnt <= '0;
    end else if (fifo_flush) begin
      rx_rp <= '0;
      if (rx_push) begin
        rx_mem[PW'(0)] <= shreg;
        rx_wp  <= PW'(1);
        rx_cnt <= (PW+1)'(1);
      end else begin
        rx_wp  <= '0;
        rx_cnt <= '0;
      end
    end else begin
      if (rx_push) begin
        rx_mem[rx_wp] <= shreg;
        rx_wp <= rx_wp + PW'(1);
      end
      if (rx_pop) rx_rp <= rx_rp + PW'(1);
      rx_cnt <= rx_cnt + (PW+1)'(rx_push) - (PW+1)'(rx_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (sync_reset) state <= S_IDLE;
    else            state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      S_IDLE:  if (enable && !cmd_empty) next_state = S_FETCH;
      S_FETCH: begin
        if (cmd_empty) next_state = S_IDLE;
        else if (fetch_go) begin
          case (head[9:8])
            OP_START: next_state = S_START;
            OP_STOP:  next_state = S_STOP;
            default:  next_state = S_XFER;
          endcase
        end
      end
      default: begin
        if (state_end) begin
          if (nack_evt)                   next_state = S_STOP;
          else if (enable && !cmd_empty)  next_state = S_FETCH;
          else                            next_state = S_IDLE;
        end
      end
    endcase
  end

  // Phase timing; a new divider value is picked up only at phase boundaries.
  always_ff @(posedge clk) begin
    if (sync_reset) begin
      q_cnt      <= 8'h00;
      q_cur      <= DEFAULT_DIV;
      phase      <= 2'd0;
      bit_cnt    <= 4'd0;
      cur_op     <= OP_START;
      cur_nack   <= 1'b0;
      cur_byte   <= 8'h00;
      shreg      <= 8'h00;
      ack_bit    <= 1'b0;
      fetch_wait <= 1'b1;
    end else begin
      fetch_wait <= (state == S_IDLE);
      if (fetch_go) begin
        cur_nack <= head[10];
        cur_op   <= head[9:8];
        cur_byte <= head[7:0];
        phase    <= 2'd0;
        bit_cnt  <= 4'd0;
        q_cnt    <= 8'h00;
        q_cur    <= q_reg;
      end else if (tick) begin
        q_cnt <= 8'h00;
        q_cur <= q_reg;
        phase <= phase + 2'd1;
        if (phase == 2'd3) bit_cnt <= bit_cnt + 4'd1;
      end else if (timed && !stretch_hold) begin
        q_cnt <= q_cnt + 8'd1;
      end
      if (sample) begin
        if (bit_cnt == 4'd8) ack_bit <= sda_in;
        else                 shreg   <= {shreg[6:0], sda_in};
      end
    end
  end

  assign tx_bit = (bit_cnt == 4'd8) ? ((cur_op == OP_READ) ? cur_nack : 1'b1)
                                    : ((cur_op == OP_READ) ? 1'b1 : cur_byte[~bit_cnt[2:0]]);

  // Idle and fetch hold the lines so a bus left mid-transaction stays put.
  always_comb begin
    sda_nxt = sda_out;
    scl_nxt = scl_out;
    case (state)
      S_FETCH: if (!fetch_wait && !cmd_empty && head[9:8] == OP_READ && rx_full) scl_nxt = 1'b0;
      S_START: begin
        sda_nxt = (phase == 2'd0);
        scl_nxt = (phase == 2'd0) || (phase == 2'd1);
      end
      S_STOP: begin
        sda_nxt = phase[1];
        scl_nxt = (phase != 2'd0);
      end
      S_XFER: begin
        sda_nxt = tx_bit;
        scl_nxt = (phase == 2'd1) || (phase == 2'd2);
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (sync_reset) begin
      sda_out <= 1'b1;
      scl_out <= 1'b1;
    end else begin
      sda_out <= sda_nxt;
      scl_out <= scl_nxt;
    end
  end

  assign status    = {state != S_IDLE, nack_seen, cmd_full, cmd_empty, rx_full, rx_empty, overflow, enable};
  assign ack_o     = stb_i;
  assign dbg_state = state;

  always_comb begin
    dat_o = 8'h00;
    if (adr_rd_i == REG_ADDR_CSR)       dat_o = status;
    else if (adr_rd_i == REG_ADDR_DATA) dat_o = rx_empty ? 8'h00 : rx_mem[rx_rp];
    else if (adr_rd_i == REG_ADDR_DIV)  dat_o = q_reg;
  end
endmodule
